instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_instruction_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instruction_encoder
// Description : Encodes RV32 instruction fields and an immediate into a
//               32-bit instruction word. One request stage (S1) feeds a
//               small output FIFO. Requests whose opcode or immediate
//               cannot be encoded produce a zero word flagged as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_error,
  output logic [15:0] ok_count,
  output logic [15:0] err_count
);

  localparam int c_ptr_w = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(OUT_DEPTH) + 1;

  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_load_fp  = 7'b0000111;
  localparam logic [6:0] c_op_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_store_fp = 7'b0100111;
  localparam logic [6:0] c_op_op       = 7'b0110011;
  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_BAD
  } fmt_t;

  // S1 request register
  logic        r_s1_valid;
  logic [6:0]  r_s1_op;
  logic [2:0]  r_s1_f3;
  logic [6:0]  r_s1_f7;
  logic [4:0]  r_s1_rd;
  logic [4:0]  r_s1_rs1;
  logic [4:0]  r_s1_rs2;
  logic [31:0] r_s1_imm;

  // Output FIFO
  logic [31:0]        r_mem_inst [OUT_DEPTH];
  logic               r_mem_err  [OUT_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  fmt_t        w_fmt;
  logic [31:0] w_inst;
  logic        w_err;
  logic        w_pop;
  logic        w_push;
  logic        w_s1_move;
  logic        w_accept;
  logic        w_full;

  assign w_full    = (r_count == c_cnt_w'(OUT_DEPTH));
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  // S1 may drain into the FIFO when there is room, including room freed by a pop
  assign w_s1_move = r_s1_valid && (!w_full || w_pop);
  assign w_push    = w_s1_move && !flush;
  assign in_ready  = !r_s1_valid || w_s1_move;
  assign w_accept  = in_valid && in_ready;
  assign out_inst  = out_valid ? r_mem_inst[r_rd_ptr] : 32'h0;
  assign out_error = out_valid ? r_mem_err[r_rd_ptr]  : 1'b0;

  // Classify the S1 request by opcode into an encoding format
  always_comb begin
    w_fmt = FMT_BAD;
    case (r_s1_op)
      c_op_load, c_op_load_fp, c_op_op_imm, c_op_jalr: w_fmt = FMT_I;
      c_op_store, c_op_store_fp:                        w_fmt = FMT_S;
      c_op_branch:                                      w_fmt = FMT_B;
      c_op_lui, c_op_auipc:                             w_fmt = FMT_U;
      c_op_jal:                                         w_fmt = FMT_J;
      c_op_op:                                          w_fmt = FMT_R;
      default:                                          w_fmt = FMT_BAD;
    endcase
  end

  // Range-check the immediate and assemble the instruction word
  always_comb begin
    w_inst = 32'h0;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_I: begin
        w_err  = !((&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]));
        w_inst = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      end
      FMT_S: begin
        w_err  = !((&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]));
        w_inst = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                  r_s1_imm[4:0], r_s1_op};
      end
      FMT_B: begin
        w_err  = !((&r_s1_imm[31:12]) || !(|r_s1_imm[31:12])) || r_s1_imm[0];
        w_inst = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                  r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
      end
      FMT_U: begin
        w_err  = (r_s1_imm[11:0] != 12'h0);
        w_inst = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
      end
      FMT_J: begin
        w_err  = !((&r_s1_imm[31:20]) || !(|r_s1_imm[31:20])) || r_s1_imm[0];
        w_inst = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                  r_s1_rd, r_s1_op};
      end
      FMT_R: begin
        w_inst = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      end
      default: w_err = 1'b1;
    endcase
    // Unencodable requests carry a zero word so consumers never see garbage
    if (w_err) begin
      w_inst = 32'h0;
    end
  end

  // Capture accepted requests into S1; release S1 when it drains to the FIFO
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_f3    <= '0;
      r_s1_f7    <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_imm   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= in_opcode;
      r_s1_f3    <= in_funct3;
      r_s1_f7    <= in_funct7;
      r_s1_rd    <= in_rd;
      r_s1_rs1   <= in_rs1;
      r_s1_rs2   <= in_rs2;
      r_s1_imm   <= in_imm;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  // FIFO storage; contents are only observed through out_valid so no reset
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= w_inst;
      r_mem_err[r_wr_ptr]  <= w_err;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_cnt_w'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_cnt_w'(1);
      end
    end
  end

  // Saturating tallies of popped good and error words; flush does not clear them
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ok_count  <= 16'h0;
      err_count <= 16'h0;
    end else if (w_pop && !flush) begin
      if (out_error) begin
        if (err_count != 16'hFFFF) begin
          err_count <= err_count + 16'h1;
        end
      end else begin
        if (ok_count != 16'hFFFF) begin
          ok_count <= ok_count + 16'h1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_encoder
// Description : Scoreboard bench for instruction_encoder. Directed cases and
//               randomized requests; expected words come from a field-level
//               reference model and are re-checked by decoding immediates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_error;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  instruction_encoder #(.OUT_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_error(out_error),
    .ok_count(ok_count), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3,
                         F_J = 3'd4, F_R = 3'd5, F_X = 3'd6;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_ok = 0;
  int   exp_err = 0;
  bit   rand_mode = 0;

  logic [6:0] i_ops [4] = '{7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111};
  logic [6:0] s_ops [2] = '{7'b0100011, 7'b0100111};
  logic [6:0] u_ops [2] = '{7'b0110111, 7'b0010111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: format from opcode, legality from signed ranges, word by arithmetic
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    exp_t e;
    int   si;
    logic [31:0] base;
    si = $signed(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12);
    e.imm = imm;
    e.err = 1'b0;
    e.inst = 32'h0;
    case (op)
      7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111: e.fmt = F_I;
      7'b0100011, 7'b0100111: e.fmt = F_S;
      7'b1100011: e.fmt = F_B;
      7'b0110111, 7'b0010111: e.fmt = F_U;
      7'b1101111: e.fmt = F_J;
      7'b0110011: e.fmt = F_R;
      default: e.fmt = F_X;
    endcase
    case (e.fmt)
      F_I: begin
        e.err = !(si >= -2048 && si <= 2047);
        e.inst = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7) | 32'(op);
      end
      F_S: begin
        e.err = !(si >= -2048 && si <= 2047);
        e.inst = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base
               | ((imm & 32'h1F) << 7) | 32'(op);
      end
      F_B: begin
        e.err = !(si >= -4096 && si <= 4095) || (imm[0] == 1'b1);
        e.inst = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
               | (32'(rs2) << 20) | base | (((imm >> 1) & 32'hF) << 8)
               | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      end
      F_U: begin
        e.err = ((imm % 4096) != 0);
        e.inst = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      end
      F_J: begin
        e.err = !(si >= -1048576 && si <= 1048575) || (imm[0] == 1'b1);
        e.inst = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
               | (32'(rd) << 7) | 32'(op);
      end
      F_R: begin
        e.inst = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'(op);
      end
      default: e.err = 1'b1;
    endcase
    if (e.err) e.inst = 32'h0;
    return e;
  endfunction

  // Immediate generator: recovers the immediate carried by an encoded word
  function automatic logic [31:0] immgen(input logic [31:0] w, input logic [2:0] fmt);
    case (fmt)
      F_I: return {{20{w[31]}}, w[31:20]};
      F_S: return {{20{w[31]}}, w[31:25], w[11:7]};
      F_B: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      F_U: return {w[31:12], 12'h0};
      F_J: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Stimulus side of the scoreboard: record each accepted request
  always @(negedge clock) begin
    if (reset_n && flush) begin
      sb.delete();
    end else if (reset_n && in_valid && in_ready) begin
      sb.push_back(model(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm));
    end
  end

  // Monitor: compare every popped word against the oldest expected entry
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", out_inst, 32'hxxxxxxxx);
      end else begin
        e = sb.pop_front();
        check("out_inst", out_inst, e.inst);
        check("out_error", {31'b0, out_error}, {31'b0, e.err});
        if (!e.err && e.fmt <= F_J) begin
          check("roundtrip_imm", immgen(out_inst, e.fmt), e.imm);
        end
        if (e.err) exp_err = (exp_err < 65535) ? exp_err + 1 : exp_err;
        else       exp_ok  = (exp_ok  < 65535) ? exp_ok  + 1 : exp_ok;
      end
    end
  end

  task automatic step_ready();
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    bit acc;
    int n;
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    acc = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      step_ready();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'h0);
    check("drain_ok_count", {16'h0, ok_count}, 32'(exp_ok));
    check("drain_err_count", {16'h0, err_count}, 32'(exp_err));
  endtask

  // Hold in_valid for ncyc cycles with changing fields and count accepts
  task automatic fill(input int ncyc, output int acc);
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      in_opcode = 7'b0010011; in_funct3 = 3'(i); in_funct7 = 7'h0;
      in_rd = 5'(i + 1); in_rs1 = 5'(i + 2); in_rs2 = 5'h0; in_imm = 32'(i * 3);
      @(negedge clock);
      if (in_ready) acc++;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int ok_before;
    logic [15:0] sv_ok, sv_err;
    logic [31:0] r;
    logic [6:0] op;
    int k;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_out_error", {31'b0, out_error}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_ok_count", {16'h0, ok_count}, 32'h0);
    check("rst_err_count", {16'h0, err_count}, 32'h0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Latency and the addi example
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    check("lat_after_accept_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clock);
    #1;
    check("lat_next_edge_valid", {31'b0, out_valid}, 32'h1);
    check("addi_word", out_inst, 32'hFFF00093);
    drain();

    // Branch legal and odd immediate
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    drain();
    check("branch_err_count", {16'h0, err_count}, 32'd1);

    // LUI legal and with nonzero low bits
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    @(posedge clock);
    #1;
    check("lui_word", out_inst, 32'h123452B7);
    send(7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001);
    drain();
    check("lui_err_count", {16'h0, err_count}, 32'd2);

    // Back-pressure: S1 plus two FIFO entries, then in_ready drops
    ok_before = int'(ok_count);
    out_ready = 1'b0;
    fill(8, acc);
    check("bp_accepts", 32'(acc), 32'd3);
    check("bp_in_ready", {31'b0, in_ready}, 32'h0);
    drain();
    check("bp_ok_delta", 32'(int'(ok_count) - ok_before), 32'd3);

    // Asynchronous reset with three entries buffered
    out_ready = 1'b0;
    fill(6, acc);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_out_inst", out_inst, 32'h0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("mid_rst_ok_count", {16'h0, ok_count}, 32'h0);
    check("mid_rst_err_count", {16'h0, err_count}, 32'h0);
    sb.delete();
    exp_ok = 0;
    exp_err = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send(7'b0010011, 3'd1, 7'd0, 5'd3, 5'd4, 5'd0, 32'hFFFFF800);
    check("post_rst_lat_valid0", {31'b0, out_valid}, 32'h0);
    @(posedge clock);
    #1;
    check("post_rst_lat_valid1", {31'b0, out_valid}, 32'h1);
    drain();

    // Flush with two entries buffered; counters survive
    send(7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    out_ready = 1'b0;
    fill(2, acc);
    check("flush_fill_accepts", 32'(acc), 32'd2);
    sv_ok = ok_count;
    sv_err = err_count;
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check("flush_out_valid", {31'b0, out_valid}, 32'h0);
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    check("flush_ok_kept", {16'h0, ok_count}, {16'h0, sv_ok});
    check("flush_err_kept", {16'h0, err_count}, {16'h0, sv_err});
    drain();

    // Random legal requests across I/S/B/U/J with random back-pressure
    rand_mode = 1;
    for (int n = 0; n < 10000; n++) begin
      r = $urandom;
      k = $urandom_range(0, 4);
      case (k)
        0: send(i_ops[$urandom_range(0, 3)], 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), {{20{r[11]}}, r[11:0]});
        1: send(s_ops[$urandom_range(0, 1)], 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), {{20{r[11]}}, r[11:0]});
        2: send(7'b1100011, 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), {{19{r[12]}}, r[12:1], 1'b0});
        3: send(u_ops[$urandom_range(0, 1)], 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), {r[31:12], 12'h0});
        default: send(7'b1101111, 3'($urandom), 7'($urandom), 5'($urandom),
                5'($urandom), 5'($urandom), {{11{r[20]}}, r[20:1], 1'b0});
      endcase
    end

    // Random mix including R-type, bad opcodes and out-of-range immediates
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      op = ($urandom_range(0, 1) == 0) ? 7'($urandom) : i_ops[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) op = 7'b0110011;
      if ($urandom_range(0, 1) == 0) r = {{20{r[11]}}, r[11:0]};
      send(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), r);
    end
    rand_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
